// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - streaming XOR cipher with a reusable programmable-length key buffer
module xor_stream_cipher #(
  parameter int DATA_W    = 8,
  parameter int KEY_DEPTH = 64,
  parameter int LEN_W     = $clog2(KEY_DEPTH + 1),
  parameter int CNT_W     = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iReuse_key,
  input  logic [LEN_W-1:0]  iKey_len,
  input  logic              iKey_valid,
  input  logic [DATA_W-1:0] iKey_data,
  output logic              oKey_ready,
  input  logic              iMsg_valid,
  input  logic [DATA_W-1:0] iMsg_data,
  input  logic              iMsg_last,
  output logic              oMsg_ready,
  output logic              oOut_valid,
  output logic [DATA_W-1:0] oOut_data,
  output logic              oOut_last,
  input  logic              iOut_ready,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic [CNT_W-1:0]  oCount
);

  localparam int IDX_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    STREAM   = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   key_len_q, key_len_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   key_idx_q, key_idx_d;
  logic               key_loaded_q, key_loaded_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DATA_W-1:0]  key_mem [KEY_DEPTH];
  logic               key_we;
  logic [DATA_W-1:0]  key_rd;
  logic               msg_ready;
  logic               start_bad;

  // Next-state, datapath and handshake decode for the four-state message FSM
  always_comb begin
    state_d      = state_q;
    key_len_d    = key_len_q;
    wr_ptr_d     = wr_ptr_q;
    key_idx_d    = key_idx_q;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    count_d      = count_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    key_we       = 1'b0;
    msg_ready    = 1'b0;
    key_rd       = key_mem[key_idx_q];
    start_bad    = (iKey_len == '0) || (iKey_len > LEN_W'(KEY_DEPTH)) ||
                   (iReuse_key && !key_loaded_q);

    case (state_q)
      IDLE: begin
        if (iStart) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            count_d   = '0;
            key_idx_d = '0;
            if (iReuse_key) begin
              state_d = STREAM;
            end else begin
              key_len_d    = iKey_len;
              wr_ptr_d     = '0;
              key_loaded_d = 1'b0;
              state_d      = LOAD_KEY;
            end
          end
        end
      end

      LOAD_KEY: begin
        if (iKey_valid) begin
          key_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + IDX_W'(1);
          if (LEN_W'(wr_ptr_q) == key_len_q - LEN_W'(1)) begin
            key_loaded_d = 1'b1;
            state_d      = STREAM;
          end
        end
      end

      STREAM: begin
        // One output register stage: a new symbol may enter whenever the slot frees this cycle
        msg_ready = !out_valid_q || iOut_ready;
        if (iMsg_valid && msg_ready) begin
          out_data_d  = iMsg_data ^ key_rd;
          out_last_d  = iMsg_last;
          out_valid_d = 1'b1;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
          if (LEN_W'(key_idx_q) == key_len_q - LEN_W'(1)) begin
            key_idx_d = '0;
          end else begin
            key_idx_d = key_idx_q + IDX_W'(1);
          end
          if (iMsg_last) begin
            state_d = DRAIN;
          end
        end else if (iOut_ready) begin
          out_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (out_valid_q && iOut_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any message and forgets the key
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q      <= IDLE;
      key_len_q    <= '0;
      wr_ptr_q     <= '0;
      key_idx_q    <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      key_len_q    <= key_len_d;
      wr_ptr_q     <= wr_ptr_d;
      key_idx_q    <= key_idx_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  // Key buffer write port; contents are meaningless until a load completes
  always_ff @(posedge iClk) begin
    if (key_we) begin
      key_mem[wr_ptr_q] <= iKey_data;
    end
  end

  assign oKey_ready = (state_q == LOAD_KEY);
  assign oMsg_ready = msg_ready;
  assign oOut_valid = out_valid_q;
  assign oOut_data  = out_data_q;
  assign oOut_last  = out_last_q;
  assign oBusy      = (state_q != IDLE);
  assign oDone      = done_q;
  assign oErr       = err_q;
  assign oCount     = count_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb/tb_xor_stream_cipher.sv - scoreboard bench for xor_stream_cipher
module tb_xor_stream_cipher;

  localparam int DATA_W    = 8;
  localparam int KEY_DEPTH = 64;
  localparam int LEN_W     = $clog2(KEY_DEPTH + 1);
  localparam int CNT_W     = 16;

  logic              iClk;
  logic              iRst;
  logic              iStart;
  logic              iReuse_key;
  logic [LEN_W-1:0]  iKey_len;
  logic              iKey_valid;
  logic [DATA_W-1:0] iKey_data;
  logic              oKey_ready;
  logic              iMsg_valid;
  logic [DATA_W-1:0] iMsg_data;
  logic              iMsg_last;
  logic              oMsg_ready;
  logic              oOut_valid;
  logic [DATA_W-1:0] oOut_data;
  logic              oOut_last;
  logic              iOut_ready;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
  logic [CNT_W-1:0]  oCount;

  xor_stream_cipher #(
    .DATA_W(DATA_W), .KEY_DEPTH(KEY_DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iReuse_key(iReuse_key),
    .iKey_len(iKey_len), .iKey_valid(iKey_valid), .iKey_data(iKey_data),
    .oKey_ready(oKey_ready), .iMsg_valid(iMsg_valid), .iMsg_data(iMsg_data),
    .iMsg_last(iMsg_last), .oMsg_ready(oMsg_ready), .oOut_valid(oOut_valid),
    .oOut_data(oOut_data), .oOut_last(oOut_last), .iOut_ready(iOut_ready),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] key_model [KEY_DEPTH];
  logic [7:0] msg_buf   [256];
  int         cur_len;
  int         kidx;

  logic [7:0] exp_data [$];
  logic       exp_last [$];

  bit         done_exp;
  bit         hold_pending;
  logic [7:0] hold_data;
  logic       hold_last;
  bit         key_rdy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every downstream handshake
  always @(negedge iClk) begin
    if (!iRst) begin
      done_exp     = 0;
      hold_pending = 0;
    end else begin
      if (done_exp || oDone) chk("done_pulse", {31'd0, oDone}, {31'd0, done_exp});
      done_exp = 0;
      if (hold_pending) begin
        chk("hold_valid", {31'd0, oOut_valid}, 32'd1);
        chk("hold_data", {24'd0, oOut_data}, {24'd0, hold_data});
        chk("hold_last", {31'd0, oOut_last}, {31'd0, hold_last});
      end
      hold_pending = oOut_valid && !iOut_ready;
      hold_data    = oOut_data;
      hold_last    = oOut_last;
      if (oOut_valid && iOut_ready) begin
        if (exp_data.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("out_data", {24'd0, oOut_data}, {24'd0, exp_data.pop_front()});
          chk("out_last", {31'd0, oOut_last}, {31'd0, exp_last[0]});
          if (exp_last.pop_front()) done_exp = 1;
        end
      end
      if (oKey_ready) key_rdy_seen = 1;
    end
  end

  task automatic start_msg(input bit reuse, input int len);
    iStart     = 1'b1;
    iReuse_key = reuse;
    iKey_len   = len[LEN_W-1:0];
    tick();
    iStart     = 1'b0;
    iReuse_key = 1'b0;
    kidx       = 0;
    if (!reuse) cur_len = len;
  endtask

  task automatic load_key(input int len);
    int i = 0;
    int cyc = 0;
    while (i < len && cyc < 500) begin
      iKey_valid = 1'b1;
      iKey_data  = key_model[i];
      @(negedge iClk);
      if (oKey_ready) i++;
      tick();
      cyc++;
    end
    iKey_valid = 1'b0;
    chk("key_load_count", i, len);
  endtask

  task automatic send_msg(input int n, input bit stall, input int abort_at);
    int  i = 0;
    int  cyc = 0;
    bit  acc_prev = 0;
    bit  got = 0;
    bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (i < n && cyc < 2000 && !(abort_at > 0 && i >= abort_at)) begin
      iOut_ready = stall ? pat[cyc % 4] : 1'b1;
      iMsg_valid = 1'b1;
      iMsg_data  = msg_buf[i];
      iMsg_last  = (i == n - 1);
      @(negedge iClk);
      if (acc_prev) chk("latency_1", {31'd0, oOut_valid}, 32'd1);
      if (stall && oOut_valid && !iOut_ready) chk("msg_ready_stall", {31'd0, oMsg_ready}, 32'd0);
      acc_prev = oMsg_ready;
      if (oMsg_ready) begin
        exp_data.push_back(msg_buf[i] ^ key_model[kidx]);
        exp_last.push_back(i == n - 1);
        kidx = (kidx == cur_len - 1) ? 0 : kidx + 1;
        i++;
      end
      tick();
      cyc++;
    end
    iMsg_valid = 1'b0;
    iMsg_last  = 1'b0;
    if (abort_at > 0 && i >= abort_at) return;
    chk("msg_sent", i, n);
    iOut_ready = 1'b1;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge iClk);
      if (oDone) got = 1;
      tick();
      cyc++;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("count", {16'd0, oCount}, n);
    chk("busy_idle", {31'd0, oBusy}, 32'd0);
    chk("sb_empty", exp_data.size(), 0);
  endtask

  task automatic err_case(input string tag, input bit reuse, input int len);
    iStart     = 1'b1;
    iReuse_key = reuse;
    iKey_len   = len[LEN_W-1:0];
    tick();
    iStart     = 1'b0;
    iReuse_key = 1'b0;
    @(negedge iClk);
    chk({tag, "_err"}, {31'd0, oErr}, 32'd1);
    chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    tick();
    chk({tag, "_err_pulse"}, {31'd0, oErr}, 32'd0);
    chk({tag, "_idle"}, {31'd0, oBusy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, oOut_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, oOut_data}, 32'd0);
    chk({tag, "_last"}, {31'd0, oOut_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    chk({tag, "_done"}, {31'd0, oDone}, 32'd0);
    chk({tag, "_err"}, {31'd0, oErr}, 32'd0);
    chk({tag, "_count"}, {16'd0, oCount}, 32'd0);
    chk({tag, "_krdy"}, {31'd0, oKey_ready}, 32'd0);
    chk({tag, "_mrdy"}, {31'd0, oMsg_ready}, 32'd0);
  endtask

  initial begin
    iRst = 1'b0; iStart = 1'b0; iReuse_key = 1'b0; iKey_len = '0;
    iKey_valid = 1'b0; iKey_data = '0; iMsg_valid = 1'b0; iMsg_data = '0;
    iMsg_last = 1'b0; iOut_ready = 1'b0;
    cur_len = 0; kidx = 0; key_rdy_seen = 0;
    repeat (3) tick();
    check_all_zero("reset");
    iRst = 1'b1;
    tick();

    // 1: key {11,22,33,44}, six symbols, free-flowing output
    key_model[0] = 8'h11; key_model[1] = 8'h22; key_model[2] = 8'h33; key_model[3] = 8'h44;
    for (int i = 0; i < 6; i++) msg_buf[i] = 8'(i);
    start_msg(1'b0, 4);
    load_key(4);
    send_msg(6, 1'b0, 0);

    // 2: same key reloaded, downstream stalls 1,0,0,1
    start_msg(1'b0, 4);
    load_key(4);
    send_msg(6, 1'b1, 0);

    // 3: reuse stored key; FF,FF -> EE,DD
    key_rdy_seen = 0;
    msg_buf[0] = 8'hFF; msg_buf[1] = 8'hFF;
    start_msg(1'b1, 4);
    send_msg(2, 1'b0, 0);
    chk("reuse_no_key_ready", {31'd0, key_rdy_seen}, 32'd0);

    // 4: illegal starts
    err_case("len0", 1'b0, 0);
    err_case("len65", 1'b0, KEY_DEPTH + 1);
    iRst = 1'b0;
    tick();
    iRst = 1'b1;
    tick();
    err_case("reuse_unloaded", 1'b1, 4);

    // 5: full-depth key, 130 symbols wrap the key index twice
    for (int i = 0; i < KEY_DEPTH; i++) key_model[i] = 8'((i * 37 + 5) ^ 8'hA5);
    for (int i = 0; i < 130; i++) msg_buf[i] = 8'(i * 3);
    start_msg(1'b0, KEY_DEPTH);
    load_key(KEY_DEPTH);
    send_msg(130, 1'b0, 0);

    // 6: reset in the middle of a ten-symbol message
    key_model[0] = 8'h5A; key_model[1] = 8'hC3; key_model[2] = 8'h0F;
    for (int i = 0; i < 10; i++) msg_buf[i] = 8'(8'h40 + i);
    start_msg(1'b0, 3);
    load_key(3);
    send_msg(10, 1'b0, 5);
    iRst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_data.delete();
    exp_last.delete();
    tick();
    iRst = 1'b1;
    tick();
    err_case("reuse_after_reset", 1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Streaming successor to the block-wide XOR encryptor. Message symbols arrive one per handshake and are XORed with a repeating key held in an internal key buffer. The key length is programmable per message.
- Sits between the UART/byte assembler and the transmit path. Encryption and decryption are the same operation.
- Supports key reuse across messages, backpressure, and a framed end-of-message with a done pulse.

Parameters:
- DATA_W, 8: symbol width in bits, for message, key and output.
- KEY_DEPTH, 64: maximum key length in symbols. Key buffer size.
- LEN_W, $clog2(KEY_DEPTH+1): width of the key-length input.
- CNT_W, 16: width of the processed-symbol counter.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-low reset.
- iStart  in  1  start request, sampled in IDLE only.
- iReuse_key  in  1  sampled with iStart. 1 = skip key load and reuse the stored key.
- iKey_len  in  LEN_W  key length in symbols, sampled with iStart.
- iKey_valid  in  1  key symbol valid.
- iKey_data  in  DATA_W  key symbol.
- oKey_ready  out  1  key symbol accepted when valid & ready.
- iMsg_valid  in  1  message symbol valid.
- iMsg_data  in  DATA_W  message symbol.
- iMsg_last  in  1  marks the final message symbol.
- oMsg_ready  out  1  message accept.
- oOut_valid  out  1  ciphertext valid.
- oOut_data  out  DATA_W  ciphertext symbol.
- oOut_last  out  1  final ciphertext symbol.
- iOut_ready  in  1  downstream accept.
- oBusy  out  1  high in any state except IDLE.
- oDone  out  1  one-cycle pulse when the final symbol is accepted downstream.
- oErr  out  1  one-cycle pulse on an illegal start.
- oCount  out  CNT_W  symbols accepted in the current message.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM goes to IDLE; key pointers and oCount are 0; key_loaded is 0.
  - Key buffer contents are don't-care.
- Reset mid-operation aborts immediately. No output is completed and key_loaded is cleared.
- State IDLE:
  - oKey_ready=0, oMsg_ready=0.
  - On iStart, illegal cases pulse oErr the next cycle and stay in IDLE:
    - iKey_len==0 or iKey_len>KEY_DEPTH;
    - iReuse_key=1 while key_loaded=0.
  - iReuse_key=1 with key_loaded=1 → STREAM, keeping the stored length.
  - Otherwise latch key_len=iKey_len, clear wr_ptr and key_loaded → LOAD_KEY.
  - On every legal start: oCount←0 and key_idx←0.
- State LOAD_KEY:
  - oKey_ready=1.
  - Each accepted key symbol is written to key[wr_ptr], then wr_ptr++.
  - Accepting the symbol at wr_ptr==key_len-1 → STREAM and sets key_loaded=1.
  - oMsg_ready=0 throughout this state. Message symbols are never accepted before the key is complete.
- State STREAM:
  - oMsg_ready = !oOut_valid | iOut_ready. This is a single output register stage; full throughput is 1 symbol/cycle.
  - On accept:
    - oOut_data←iMsg_data^key[key_idx];
    - oOut_last←iMsg_last;
    - oOut_valid←1;
    - oCount++ (saturates at all-ones);
    - key_idx wraps to 0 after key_len-1, otherwise increments.
  - Latency: input accept to oOut_valid is exactly 1 cycle.
  - If iOut_ready is high with no new accept, oOut_valid←0.
  - Output data and last are held stable while valid & !ready.
  - Accepting a symbol with iMsg_last=1 → DRAIN. oMsg_ready is 0 from then on.
- State DRAIN:
  - When oOut_valid & iOut_ready (the last symbol is accepted): oOut_valid←0, oDone pulses 1 cycle, → IDLE.
- The key persists across messages until reset or a new load.
- iStart outside IDLE is ignored.
- Key-symbol inputs outside LOAD_KEY are ignored.
- A single-symbol message (last on the first symbol) is legal.

Test Plan:
1. Load key_len=4 key {0x11,0x22,0x33,0x44}, stream 6 symbols 0x00..0x05 with last on the 6th, iOut_ready=1 → out 0x11,0x23,0x31,0x47,0x15,0x27; oOut_last on the 6th; oDone 1 cycle after its acceptance; oCount=6.
2. Same setup, iOut_ready toggled 1,0,0,1 → no symbol dropped or duplicated; oOut_data held while stalled; oMsg_ready low during stalls.
3. Second message with iReuse_key=1, symbols 0xFF,0xFF (last) → 0xEE,0xDD (key_idx restarts at 0); oKey_ready never asserts.
4. iStart with iKey_len=0, then iKey_len=KEY_DEPTH+1, then iReuse_key=1 after reset → oErr pulses each time; FSM stays IDLE; oBusy=0.
5. key_len=KEY_DEPTH=64, stream 130 symbols → key_idx wraps twice; output symbol 64 uses key[0].
6. Assert iRst low midway through a 10-symbol message → all outputs 0 immediately; a subsequent iReuse_key start gives oErr.
